// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared entry control fields and bubble sanitizing for the elastic pipe latch
package pipe_pkg;

   localparam int PC_W = 32;
   localparam int IR_W = 32;

   localparam logic [IR_W-1:0] IR_BUBBLE = 32'h0;
   // Wide zero, sliced down to the register-address width at each use
   localparam logic [31:0]     RD_ZERO   = 32'h0;

   // Width-independent part of an entry; payload, rd and exp are sized per instance
   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic [IR_W-1:0] ir;
      logic            regwrite;
      logic            flushed;
      logic            valid;
   } ctrl_t;

   function automatic ctrl_t sanitize_ctrl(input ctrl_t c);
      ctrl_t r;
      r          = c;
      r.ir       = IR_BUBBLE;
      r.regwrite = 1'b0;
      r.flushed  = 1'b1;
      return r;
   endfunction

endpackage

// File: rtl/pipe_slot.sv
// rtl/pipe_slot.sv - one pipeline entry register with load, clear, sanitize and hold
module pipe_slot
   import pipe_pkg::*;
#(
   parameter int PAYLOAD_W = 64,
   parameter int EXP_W     = 4,
   parameter int RD_W      = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load_i,
   input  logic                 clear_i,
   input  logic                 san_i,
   input  logic [31:0]          pc_i,
   input  logic [31:0]          ir_i,
   input  logic [PAYLOAD_W-1:0] payload_i,
   input  logic [RD_W-1:0]      rd_i,
   input  logic                 regwrite_i,
   input  logic [EXP_W-1:0]     exp_i,
   input  logic                 flushed_i,
   output logic                 valid_o,
   output logic [31:0]          pc_o,
   output logic [31:0]          ir_o,
   output logic [PAYLOAD_W-1:0] payload_o,
   output logic [RD_W-1:0]      rd_o,
   output logic                 regwrite_o,
   output logic [EXP_W-1:0]     exp_o,
   output logic                 flushed_o
);

   typedef struct packed {
      ctrl_t                ctl;
      logic [PAYLOAD_W-1:0] payload;
      logic [RD_W-1:0]      rd;
      logic [EXP_W-1:0]     exp;
   } entry_t;

   entry_t ent_q, ent_d;

   always_comb begin
      ent_d = ent_q;
      if (clear_i) begin
         ent_d = '0;
      end else if (load_i) begin
         ent_d.ctl.pc       = pc_i;
         ent_d.ctl.ir       = ir_i;
         ent_d.ctl.regwrite = regwrite_i;
         ent_d.ctl.flushed  = flushed_i;
         ent_d.ctl.valid    = 1'b1;
         ent_d.payload      = payload_i;
         ent_d.rd           = rd_i;
         ent_d.exp          = exp_i;
      end
      // Sanitize whatever the slot will hold after the edge, loaded or kept
      if (san_i && ent_d.ctl.valid) begin
         ent_d.ctl = sanitize_ctrl(ent_d.ctl);
         ent_d.rd  = RD_ZERO[RD_W-1:0];
         ent_d.exp = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ent_q <= '0;
      else     ent_q <= ent_d;
   end

   assign valid_o    = ent_q.ctl.valid;
   assign pc_o       = ent_q.ctl.pc;
   assign ir_o       = ent_q.ctl.ir;
   assign regwrite_o = ent_q.ctl.regwrite;
   assign flushed_o  = ent_q.ctl.flushed;
   assign payload_o  = ent_q.payload;
   assign rd_o       = ent_q.rd;
   assign exp_o      = ent_q.exp;

endmodule

// File: rtl/pipe_latch_skid.sv
// rtl/pipe_latch_skid.sv - elastic inter-stage latch: main slot plus skid slot, drop or bubble flush
module pipe_latch_skid
   import pipe_pkg::*;
#(
   parameter int PAYLOAD_W       = 64,
   parameter int EXP_W           = 4,
   parameter int RD_W            = 5,
   parameter int BUBBLE_ON_FLUSH = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [31:0]          in_pc,
   input  logic [31:0]          in_ir,
   input  logic [PAYLOAD_W-1:0] in_payload,
   input  logic [RD_W-1:0]      in_rd,
   input  logic                 in_regwrite,
   input  logic [EXP_W-1:0]     in_exp,
   input  logic                 flush,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [31:0]          out_pc,
   output logic [31:0]          out_ir,
   output logic [PAYLOAD_W-1:0] out_payload,
   output logic [RD_W-1:0]      out_rd,
   output logic                 out_regwrite,
   output logic [EXP_W-1:0]     out_exp,
   output logic                 out_flushed,
   output logic [1:0]           occupancy
);

   localparam logic BUBBLE = (BUBBLE_ON_FLUSH != 0);

   logic                 s_valid, s_regwrite, s_flushed;
   logic [31:0]          s_pc, s_ir;
   logic [PAYLOAD_W-1:0] s_payload;
   logic [RD_W-1:0]      s_rd;
   logic [EXP_W-1:0]     s_exp;

   logic accept, consume, drop, bubble;
   logic m_load, m_clear, m_from_s, s_load, s_clear;

   // in_ready comes straight from the skid flop: no out_ready -> in_ready path
   assign in_ready = ~s_valid;
   assign accept   = in_valid & in_ready;
   assign consume  = out_valid & out_ready;
   assign drop     = flush & ~BUBBLE;
   assign bubble   = flush & BUBBLE;

   assign m_from_s = consume & s_valid;
   assign m_load   = ~drop & (m_from_s | (accept & (~out_valid | consume)));
   assign m_clear  = drop | (consume & ~s_valid & ~accept);
   assign s_load   = ~drop & accept & out_valid & ~consume;
   assign s_clear  = drop | m_from_s;

   pipe_slot #(.PAYLOAD_W(PAYLOAD_W), .EXP_W(EXP_W), .RD_W(RD_W)) u_m (
      .clk        (clk),
      .rst        (rst),
      .load_i     (m_load),
      .clear_i    (m_clear),
      .san_i      (bubble),
      .pc_i       (m_from_s ? s_pc       : in_pc),
      .ir_i       (m_from_s ? s_ir       : in_ir),
      .payload_i  (m_from_s ? s_payload  : in_payload),
      .rd_i       (m_from_s ? s_rd       : in_rd),
      .regwrite_i (m_from_s ? s_regwrite : in_regwrite),
      .exp_i      (m_from_s ? s_exp      : in_exp),
      .flushed_i  (m_from_s & s_flushed),
      .valid_o    (out_valid),
      .pc_o       (out_pc),
      .ir_o       (out_ir),
      .payload_o  (out_payload),
      .rd_o       (out_rd),
      .regwrite_o (out_regwrite),
      .exp_o      (out_exp),
      .flushed_o  (out_flushed)
   );

   pipe_slot #(.PAYLOAD_W(PAYLOAD_W), .EXP_W(EXP_W), .RD_W(RD_W)) u_s (
      .clk        (clk),
      .rst        (rst),
      .load_i     (s_load),
      .clear_i    (s_clear),
      .san_i      (bubble),
      .pc_i       (in_pc),
      .ir_i       (in_ir),
      .payload_i  (in_payload),
      .rd_i       (in_rd),
      .regwrite_i (in_regwrite),
      .exp_i      (in_exp),
      .flushed_i  (1'b0),
      .valid_o    (s_valid),
      .pc_o       (s_pc),
      .ir_o       (s_ir),
      .payload_o  (s_payload),
      .rd_o       (s_rd),
      .regwrite_o (s_regwrite),
      .exp_o      (s_exp),
      .flushed_o  (s_flushed)
   );

   assign occupancy = {1'b0, out_valid} + {1'b0, s_valid};

   // The skid slot must never hold an entry while the main slot is empty
   always @(posedge clk) begin
      if (!rst) assert (!(s_valid && !out_valid));
   end

endmodule

// File: tb/tb_pipe_latch_skid.sv
// tb/tb_pipe_latch_skid.sv - directed self-checking bench for both flush modes of pipe_latch_skid
module tb_pipe_latch_skid;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, flush, out_ready, in_regwrite;
   logic [31:0] in_pc, in_ir;
   logic [63:0] in_payload;
   logic [4:0]  in_rd;
   logic [3:0]  in_exp;

   logic        b_in_ready, b_out_valid, b_out_regwrite, b_out_flushed;
   logic [31:0] b_out_pc, b_out_ir;
   logic [63:0] b_out_payload;
   logic [4:0]  b_out_rd;
   logic [3:0]  b_out_exp;
   logic [1:0]  b_occ;

   logic        d_in_ready, d_out_valid, d_out_regwrite, d_out_flushed;
   logic [31:0] d_out_pc, d_out_ir;
   logic [63:0] d_out_payload;
   logic [4:0]  d_out_rd;
   logic [3:0]  d_out_exp;
   logic [1:0]  d_occ;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   pipe_latch_skid #(.PAYLOAD_W(64), .EXP_W(4), .RD_W(5), .BUBBLE_ON_FLUSH(1)) dut_b (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(b_in_ready),
      .in_pc(in_pc), .in_ir(in_ir), .in_payload(in_payload), .in_rd(in_rd),
      .in_regwrite(in_regwrite), .in_exp(in_exp), .flush(flush),
      .out_valid(b_out_valid), .out_ready(out_ready),
      .out_pc(b_out_pc), .out_ir(b_out_ir), .out_payload(b_out_payload), .out_rd(b_out_rd),
      .out_regwrite(b_out_regwrite), .out_exp(b_out_exp), .out_flushed(b_out_flushed),
      .occupancy(b_occ)
   );

   pipe_latch_skid #(.PAYLOAD_W(64), .EXP_W(4), .RD_W(5), .BUBBLE_ON_FLUSH(0)) dut_d (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(d_in_ready),
      .in_pc(in_pc), .in_ir(in_ir), .in_payload(in_payload), .in_rd(in_rd),
      .in_regwrite(in_regwrite), .in_exp(in_exp), .flush(flush),
      .out_valid(d_out_valid), .out_ready(out_ready),
      .out_pc(d_out_pc), .out_ir(d_out_ir), .out_payload(d_out_payload), .out_rd(d_out_rd),
      .out_regwrite(d_out_regwrite), .out_exp(d_out_exp), .out_flushed(d_out_flushed),
      .occupancy(d_occ)
   );

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [31:0] pc, input logic [31:0] ir, input logic [4:0] rd,
                       input logic rw, input logic [3:0] ex);
      in_valid    = 1'b1;
      in_pc       = pc;
      in_ir       = ir;
      in_payload  = {32'hCAFE0000, pc};
      in_rd       = rd;
      in_regwrite = rw;
      in_exp      = ex;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
      in_pc = '0; in_ir = '0; in_payload = '0; in_rd = '0; in_regwrite = 1'b0; in_exp = '0;

      #12;
      chk("rst_out_valid", b_out_valid, 0);
      chk("rst_occ", b_occ, 0);
      chk("rst_out_pc", b_out_pc, 0);
      chk("rst_flushed", b_out_flushed, 0);
      step();
      rst = 1'b0;
      chk("rst_in_ready", b_in_ready, 1);

      // Streaming
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         beat(32'h100 + 32'(4 * i), 32'h13, 5'd1, 1'b1, 4'h0);
         step();
         chk($sformatf("stream_valid_%0d", i), b_out_valid, 1);
         chk($sformatf("stream_pc_%0d", i), b_out_pc, 32'h100 + 32'(4 * i));
         chk($sformatf("stream_occ_%0d", i), b_occ, 1);
         chk($sformatf("stream_ready_%0d", i), b_in_ready, 1);
         chk($sformatf("stream_flushed_%0d", i), b_out_flushed, 0);
      end
      in_valid = 1'b0;
      step();
      chk("stream_drain", b_out_valid, 0);

      // Backpressure
      out_ready = 1'b0;
      beat(32'h200, 32'h13, 5'd2, 1'b1, 4'h0);
      step();
      chk("bp_occ1", b_occ, 1);
      beat(32'h204, 32'h13, 5'd3, 1'b1, 4'h0);
      step();
      in_valid = 1'b0;
      chk("bp_head", b_out_pc, 32'h200);
      chk("bp_occ2", b_occ, 2);
      chk("bp_in_ready", b_in_ready, 0);
      step();
      chk("bp_hold", b_out_pc, 32'h200);
      out_ready = 1'b1;
      step();
      chk("bp_second", b_out_pc, 32'h204);
      chk("bp_ready_back", b_in_ready, 1);
      step();
      chk("bp_empty", b_out_valid, 0);

      // Bubble flush with two held entries
      out_ready = 1'b0;
      beat(32'h300, 32'h00A00093, 5'd1, 1'b1, 4'h2);
      step();
      beat(32'h304, 32'h00A00093, 5'd1, 1'b1, 4'h2);
      step();
      in_valid = 1'b0;
      chk("bf_pre_ir", b_out_ir, 32'h00A00093);
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("bf_occ", b_occ, 2);
      chk("bf_pc0", b_out_pc, 32'h300);
      chk("bf_ir0", b_out_ir, 0);
      chk("bf_rd0", b_out_rd, 0);
      chk("bf_rw0", b_out_regwrite, 0);
      chk("bf_exp0", b_out_exp, 0);
      chk("bf_fl0", b_out_flushed, 1);
      chk("bf_payload0", b_out_payload, 64'hCAFE0000_00000300);
      out_ready = 1'b1;
      step();
      chk("bf_pc1", b_out_pc, 32'h304);
      chk("bf_ir1", b_out_ir, 0);
      chk("bf_exp1", b_out_exp, 0);
      chk("bf_fl1", b_out_flushed, 1);
      step();
      chk("bf_empty", b_out_valid, 0);

      // Drop flush with two held entries and an offered beat
      out_ready = 1'b0;
      beat(32'h3F0, 32'h13, 5'd4, 1'b1, 4'h0);
      step();
      beat(32'h3F4, 32'h13, 5'd4, 1'b1, 4'h0);
      step();
      chk("df_occ_pre", d_occ, 2);
      beat(32'h400, 32'h13, 5'd4, 1'b1, 4'h0);
      flush = 1'b1;
      step();
      flush = 1'b0;
      in_valid = 1'b0;
      chk("df_occ", d_occ, 0);
      chk("df_valid", d_out_valid, 0);
      chk("df_in_ready", d_in_ready, 1);
      step();
      chk("df_no_400", d_out_valid, 0);
      beat(32'h440, 32'h13, 5'd4, 1'b1, 4'h0);
      flush = 1'b1;
      chk("df_taken_ready", d_in_ready, 1);
      step();
      flush = 1'b0;
      in_valid = 1'b0;
      chk("df_accept_dropped", d_out_valid, 0);
      out_ready = 1'b1;
      step();
      step();
      chk("df_b_drained", b_occ, 0);

      // Consume during bubble flush
      out_ready = 1'b0;
      beat(32'h500, 32'h13, 5'd7, 1'b1, 4'h1);
      step();
      chk("cf_occ", b_occ, 1);
      beat(32'h504, 32'h13, 5'd7, 1'b1, 4'h1);
      out_ready = 1'b1;
      flush = 1'b1;
      #1;
      chk("cf_leave_pc", b_out_pc, 32'h500);
      chk("cf_leave_rd", b_out_rd, 7);
      chk("cf_leave_fl", b_out_flushed, 0);
      step();
      flush = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      chk("cf_next_pc", b_out_pc, 32'h504);
      chk("cf_next_fl", b_out_flushed, 1);
      chk("cf_next_rd", b_out_rd, 0);
      chk("cf_next_occ", b_occ, 1);

      // Async reset mid-cycle with two held entries
      beat(32'h600, 32'h13, 5'd5, 1'b1, 4'h0);
      step();
      chk("ar_occ_pre", b_occ, 2);
      in_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk("ar_occ", b_occ, 0);
      chk("ar_valid", b_out_valid, 0);
      chk("ar_pc", b_out_pc, 0);
      chk("ar_in_ready", b_in_ready, 1);
      #2;
      rst = 1'b0;
      beat(32'h700, 32'h13, 5'd6, 1'b1, 4'h0);
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      chk("ar_first_valid", b_out_valid, 1);
      chk("ar_first_pc", b_out_pc, 32'h700);
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
